codificador_prioridad: RTL and testbench

CODIFICADOR_PRIORIDAD -- requirements
Module: codificador_prioridad

---
 rtl/codificador_prioridad.sv | 84 ++++++++
 tb/tb_codificador_prioridad.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_prioridad.sv
// Priority encoder with a pending-request register and a grant/ack handshake.
// The highest pending index is granted and held until the consumer acknowledges it.
// Requests that arrive for an index that is already pending set a sticky overflow flag.
module codificador_prioridad (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ent,
  input  logic       dis,
  input  logic       ack,
  output logic [2:0] sal,
  output logic       valido,
  output logic [7:0] pend,
  output logic       desborde
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned W_IDX = 3;

  typedef enum logic {LIBRE, OCUPADO} estado_t;

  estado_t          r_estado;
  logic [N_REQ-1:0] r_pend;
  logic [W_IDX-1:0] r_sal;
  logic             r_valido;
  logic             r_desborde;

  logic [W_IDX-1:0] w_idx;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_pend_next;
  logic             w_colision;

  // Index of the highest set bit of pend (later iterations override earlier ones)
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_pend[i]) w_idx = W_IDX'(i);
    end
  end

  // One-hot clear of the granted bit on an acknowledged cycle, pend update and collision detect
  always_comb begin
    w_clr       = '0;
    if (r_estado == OCUPADO && ack) w_clr = N_REQ'(1) << r_sal;
    w_pend_next = (r_pend & ~w_clr) | ent;
    w_colision  = |(ent & r_pend & ~w_clr);
  end

  // Grant FSM with the pending register and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= LIBRE;
      r_pend     <= '0;
      r_sal      <= '0;
      r_valido   <= 1'b0;
      r_desborde <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      if (w_colision) r_desborde <= 1'b1;
      case (r_estado)
        LIBRE: begin
          if (!dis && (r_pend != '0)) begin
            r_sal    <= w_idx;
            r_valido <= 1'b1;
            r_estado <= OCUPADO;
          end else begin
            r_valido <= 1'b0;
          end
        end
        OCUPADO: begin
          if (ack) begin
            r_valido <= 1'b0;
            r_estado <= LIBRE;
          end
        end
      endcase
    end
  end

  assign sal      = r_sal;
  assign valido   = r_valido;
  assign pend     = r_pend;
  assign desborde = r_desborde;

endmodule

// File: tb/tb_codificador_prioridad.sv
// Directed bench for codificador_prioridad.
// Each step compares the packed observation {sal, valido, pend, desborde} against a hand-computed value.
module tb_codificador_prioridad;

  logic       clk;
  logic       rst;
  logic [7:0] ent;
  logic       dis;
  logic       ack;
  logic [2:0] sal;
  logic       valido;
  logic [7:0] pend;
  logic       desborde;

  int checks = 0;
  int errors = 0;

  logic [12:0] obs;
  logic [12:0] exp_v;

  codificador_prioridad dut (
    .clk      (clk),
    .rst      (rst),
    .ent      (ent),
    .dis      (dis),
    .ack      (ack),
    .sal      (sal),
    .valido   (valido),
    .pend     (pend),
    .desborde (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse used to start scenarios from a clean state
  task automatic do_reset();
    ent = 8'h00; dis = 1'b0; ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ent = 8'h00; dis = 1'b0; ack = 1'b0;
    #3;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b0, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL reset_async got=%h exp=%h", obs, exp_v); errors++; end
    tick();
    obs = {sal, valido, pend, desborde};
    checks++; if (obs !== exp_v) begin $display("FAIL reset_held got=%h exp=%h", obs, exp_v); errors++; end
    rst = 1'b0;
  endtask

  task automatic test_single();
    ent = 8'h20;
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b0, 8'h20, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL single_capture got=%h exp=%h", obs, exp_v); errors++; end
    ent = 8'h00;
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd5, 1'b1, 8'h20, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL single_grant got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd5, 1'b0, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL single_ack got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde};
    checks++; if (obs !== exp_v) begin $display("FAIL ack_in_libre got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  task automatic test_priority();
    ent = 8'h81;
    tick();
    ent = 8'h00;
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd7, 1'b1, 8'h81, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL prio_first got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd7, 1'b0, 8'h01, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL prio_idle got=%h exp=%h", obs, exp_v); errors++; end
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b1, 8'h01, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL prio_second got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b0, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL prio_end got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  task automatic test_disable();
    dis = 1'b1; ent = 8'h04;
    tick();
    ent = 8'h00;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b0, 8'h04, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL dis_capture got=%h exp=%h", obs, exp_v); errors++; end
    tick();
    obs = {sal, valido, pend, desborde};
    checks++; if (obs !== exp_v) begin $display("FAIL dis_block got=%h exp=%h", obs, exp_v); errors++; end
    dis = 1'b0;
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd2, 1'b1, 8'h04, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL dis_release got=%h exp=%h", obs, exp_v); errors++; end
    dis = 1'b1;
    tick();
    obs = {sal, valido, pend, desborde};
    checks++; if (obs !== exp_v) begin $display("FAIL dis_no_abort got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0; dis = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd2, 1'b0, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL dis_ack got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  task automatic test_back_to_back();
    ent = 8'h02;
    tick();
    ent = 8'h00;
    tick();
    ent = 8'h80;
    tick();
    ent = 8'h00;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd1, 1'b1, 8'h82, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL b2b_no_preempt got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd1, 1'b0, 8'h80, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL b2b_ack got=%h exp=%h", obs, exp_v); errors++; end
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd7, 1'b1, 8'h80, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL b2b_next got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd7, 1'b0, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL b2b_end got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  task automatic test_collision();
    do_reset();
    ent = 8'h08;
    tick();
    ent = 8'h00;
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd3, 1'b1, 8'h08, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL coll_grant got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1; ent = 8'h08;
    tick();
    ack = 1'b0; ent = 8'h00;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd3, 1'b0, 8'h08, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL coll_set_clear got=%h exp=%h", obs, exp_v); errors++; end
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd3, 1'b1, 8'h08, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL coll_regrant got=%h exp=%h", obs, exp_v); errors++; end
    ent = 8'h08;
    tick();
    ent = 8'h00;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd3, 1'b1, 8'h08, 1'b1};
    checks++; if (obs !== exp_v) begin $display("FAIL coll_overflow got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd3, 1'b0, 8'h00, 1'b1};
    checks++; if (obs !== exp_v) begin $display("FAIL coll_sticky got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  task automatic test_hold();
    do_reset();
    ent = 8'h10;
    tick();
    ent = 8'h00;
    tick();
    ent = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      obs = {sal, valido, 9'h000}; exp_v = {3'd4, 1'b1, 9'h000};
      checks++; if (obs !== exp_v) begin $display("FAIL hold_cycle%0d got=%h exp=%h", k, obs, exp_v); errors++; end
    end
    ent = 8'h00;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd4, 1'b1, 8'hFF, 1'b1};
    checks++; if (obs !== exp_v) begin $display("FAIL hold_final got=%h exp=%h", obs, exp_v); errors++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd4, 1'b0, 8'hEF, 1'b1};
    checks++; if (obs !== exp_v) begin $display("FAIL hold_ack got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ent = 8'h41;
    tick();
    ent = 8'h00;
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd6, 1'b1, 8'h41, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL mid_pre got=%h exp=%h", obs, exp_v); errors++; end
    #2 rst = 1'b1;
    #1;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b0, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL mid_async got=%h exp=%h", obs, exp_v); errors++; end
    #2 rst = 1'b0;
    ent = 8'h02;
    tick();
    ent = 8'h00;
    obs = {sal, valido, pend, desborde}; exp_v = {3'd0, 1'b0, 8'h02, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL mid_first_edge got=%h exp=%h", obs, exp_v); errors++; end
    tick();
    obs = {sal, valido, pend, desborde}; exp_v = {3'd1, 1'b1, 8'h02, 1'b0};
    checks++; if (obs !== exp_v) begin $display("FAIL mid_after got=%h exp=%h", obs, exp_v); errors++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_disable();
    test_back_to_back();
    test_collision();
    test_hold();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
